window_gen_3x3: RTL and testbench
=================================

WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 Parameter SIZE, default 8: pixel width in bits.
REQ-002 Parameter IMG_WIDTH, default 16: pixels per line, legal range 3..1024.
REQ-003 Parameter IMG_HEIGHT, default 16: lines per frame, legal range 3..1024.
REQ-004 clk  input  1  sole clock; all logic updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 pix_in  input  SIZE  raster-order pixel data.
REQ-007 pix_valid  input  1  pix_in is accepted on every clk edge where this is high.
REQ-008 window  output  9*SIZE  packed {p1..p9}, row-major, p1 is top-left and p9 is bottom-right; directly compatible with the 9-value sort input bus.
REQ-009 win_valid  output  1  one-cycle pulse marking a new window.
REQ-010 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-011 Internal counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the position of the next accepted pixel, and SHALL advance only on accepted pixels.
REQ-012 col wrap: col==IMG_WIDTH-1 SHALL give col=0 and row+1; row==IMG_HEIGHT-1 together with col==IMG_WIDTH-1 SHALL give row=0, col=0.
REQ-013 Two line buffers, each IMG_WIDTH x SIZE, SHALL hold the previous two lines; an accepted pixel SHALL be written at index col after the older values at col are read out.
REQ-014 A 3x3 register array SHALL shift one column left per accepted pixel, loading the new column {line-2, line-1, pix_in}.
REQ-015 Window rule: a pixel accepted at (r,c) with r>=2 and c>=2 SHALL cause win_valid=1 on the next cycle, with window = pixels (r-2..r, c-2..c).
REQ-016 Latency: window and win_valid SHALL appear exactly 1 cycle after the accepting edge.
REQ-017 Border positions (r<2 or c<2) SHALL produce no win_valid; each frame SHALL yield exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
REQ-018 A column taken from a previous line SHALL never enter a window: the shift array SHALL be refilled at each line start.
REQ-019 When pix_valid is low: no state changes, win_valid=0, window holds its last value.
REQ-020 frame_done SHALL be 1 in the cycle after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted, coincident with that pixel's win_valid.
REQ-021 The next frame SHALL begin with no extra cycle, and its windows SHALL never use lines from the previous frame.

Reset
REQ-022 With rst=1 at a clk edge: col=0, row=0, window=0, win_valid=0, frame_done=0.
REQ-023 Line-buffer contents need not be cleared by reset; REQ-018 and REQ-021 guarantee they are never exposed in a window.
REQ-024 rst SHALL have priority over pix_valid; a pixel presented in the same cycle as rst is dropped.
REQ-025 Reset mid-frame SHALL abandon the frame; the next accepted pixel is (0,0).

Configuration
REQ-026 Macro WINDOW_SOF_EN SHALL control the sof feature.
REQ-027 With WINDOW_SOF_EN defined:
- input port sof (1 bit) exists.
- sof=1 together with pix_valid=1 SHALL treat pix_in as pixel (0,0) of a new frame, regardless of the counters.
- sof=1 with pix_valid=0 SHALL be ignored.
- An interrupted frame SHALL NOT assert frame_done.
REQ-028 Without WINDOW_SOF_EN: no sof port; frame alignment SHALL come from reset and counter wrap only.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, SIZE=8, pixel value = raster index 0..15)
REQ-029 Continuous pix_valid over 16 pixels:
- window {0,1,2,4,5,6,8,9,10} one cycle after pixel 10.
- then windows {1,2,3,5,6,7,9,10,11}, {4,5,6,8,9,10,12,13,14}, {5,6,7,9,10,11,13,14,15}.
- 4 win_valid pulses total; frame_done with the last window.
REQ-030 Same frame with pix_valid low on every other cycle: identical windows in the same order; win_valid never high in a gap cycle.
REQ-031 Two back-to-back frames, second frame valued 100+index: second frame's first window is {100,101,102,104,105,106,108,109,110}.
REQ-032 rst asserted after pixel 9, then a full frame: no window containing pre-reset data; exactly 4 windows, matching REQ-029.
REQ-033 WINDOW_SOF_EN: sof with pixel 6 of frame one, then 16 pixels 0..15: no frame_done for the interrupted frame; windows match REQ-029.

Source files
------------

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream, using two line buffers and a 3x3 shift array.
// Optional WINDOW_SOF_EN adds a sof input that forces the accepted pixel to be (0,0) of a new frame.
module window_gen_3x3 #(
  parameter int SIZE       = 8,
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef WINDOW_SOF_EN
  input  logic              sof,
`endif
  input  logic [SIZE-1:0]   pix_in,
  input  logic              pix_valid,
  output logic [9*SIZE-1:0] window,
  output logic              win_valid,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          restart;
  logic          accept;

  logic [SIZE-1:0] line1 [IMG_WIDTH];
  logic [SIZE-1:0] line2 [IMG_WIDTH];
  logic [SIZE-1:0] up1;
  logic [SIZE-1:0] up2;

  logic [SIZE-1:0] sa [3][3];

`ifdef WINDOW_SOF_EN
  assign restart = sof;
`else
  assign restart = 1'b0;
`endif

  // Position of the pixel being presented; sof overrides the counters.
  assign cur_col = restart ? '0 : col;
  assign cur_row = restart ? '0 : row;
  assign accept  = pix_valid && !rst;

  assign up1 = line1[cur_col];
  assign up2 = line2[cur_col];

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  // Line buffers are left uncleared; border suppression keeps stale lines out of every window.
  always_ff @(posedge clk) begin
    if (accept) begin
      line2[cur_col] <= up1;
      line1[cur_col] <= pix_in;
    end
  end

  // Column 2 is the newest; after two shifts into a new line, no previous-line column remains.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          sa[i][j] <= '0;
        end
      end
    end else if (pix_valid) begin
      for (int i = 0; i < 3; i++) begin
        sa[i][0] <= sa[i][1];
        sa[i][1] <= sa[i][2];
      end
      sa[0][2] <= up2;
      sa[1][2] <= up1;
      sa[2][2] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= pix_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      frame_done <= pix_valid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end
  end

  assign window = {sa[0][0], sa[0][1], sa[0][2],
                   sa[1][0], sa[1][1], sa[1][2],
                   sa[2][0], sa[2][1], sa[2][2]};

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3: directed frames plus randomized traffic against an image-array model.
// Build with WINDOW_SOF_EN defined to also exercise the sof input.
module tb_window_gen_3x3;

  localparam int SIZE = 8;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int WW   = 9 * SIZE;
`ifdef WINDOW_SOF_EN
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            pix_valid;
  logic [SIZE-1:0] pix_in;
  logic [WW-1:0]   window;
  logic            win_valid;
  logic            frame_done;
`ifdef WINDOW_SOF_EN
  logic            sof;
`endif

  int errors  = 0;
  int checks  = 0;
  int m_row   = 0;
  int m_col   = 0;
  int win_cnt = 0;
  logic [SIZE-1:0] img [H][W];

  window_gen_3x3 #(.SIZE(SIZE), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef WINDOW_SOF_EN
    .sof        (sof),
`endif
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .window     (window),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Window of a raster-index image whose top-left pixel has value base.
  function automatic logic [WW-1:0] win_of(input int base);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(8 - (i * 3 + j)) * SIZE +: SIZE] = SIZE'(base + i * W + j);
    return w;
  endfunction

  // One clock of stimulus; the model tracks the frame as a 2-D image and predicts the next-cycle outputs.
  task automatic applyStimulus(input logic do_rst, input logic valid, input logic [SIZE-1:0] pix,
                               input logic do_sof);
    logic          exp_wv;
    logic          exp_fd;
    logic [WW-1:0] exp_win;
    @(negedge clk);
    rst       = do_rst;
    pix_valid = valid;
    pix_in    = pix;
`ifdef WINDOW_SOF_EN
    sof       = do_sof;
`endif
    exp_wv  = 1'b0;
    exp_fd  = 1'b0;
    exp_win = '0;
    if (do_rst) begin
      m_row   = 0;
      m_col   = 0;
      win_cnt = 0;
    end else if (valid) begin
      if (do_sof && SOF_EN) begin
        m_row   = 0;
        m_col   = 0;
        win_cnt = 0;
      end
      img[m_row][m_col] = pix;
      if (m_row >= 2 && m_col >= 2) begin
        exp_wv = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_win[(8 - (i * 3 + j)) * SIZE +: SIZE] = img[m_row - 2 + i][m_col - 2 + j];
      end
      exp_fd = (m_row == H - 1) && (m_col == W - 1);
      m_col++;
      if (m_col == W) begin
        m_col = 0;
        m_row = (m_row + 1) % H;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("win_valid", WW'(win_valid), WW'(exp_wv));
    checkOutput("frame_done", WW'(frame_done), WW'(exp_fd));
    if (do_rst) checkOutput("reset_window", window, '0);
    if (exp_wv) checkOutput("window", window, exp_win);
    if (win_valid) win_cnt++;
    if (frame_done) begin
      checkOutput("win_count", WW'(win_cnt), WW'((W - 2) * (H - 2)));
      win_cnt = 0;
    end
  endtask

  task automatic sendFrame(input int offset, input bit gaps, input bit sof_first);
    for (int i = 0; i < W * H; i++) begin
      if (gaps) applyStimulus(1'b0, 1'b0, SIZE'($urandom), 1'b0);
      applyStimulus(1'b0, 1'b1, SIZE'(offset + i), sof_first && (i == 0));
      if (i == 10) checkOutput("first_win", window, win_of(offset));
      if (i == 15) checkOutput("last_win", window, win_of(offset + 5));
    end
  endtask

  initial begin
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_in    = '0;
`ifdef WINDOW_SOF_EN
    sof       = 1'b0;
`endif
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0);

    sendFrame(0, 1'b0, 1'b0);
    sendFrame(0, 1'b1, 1'b0);
    sendFrame(100, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, SIZE'(50 + i), 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    sendFrame(0, 1'b0, 1'b0);

    if (SOF_EN) begin
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, SIZE'(200 + i), 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h4D, 1'b1);
      sendFrame(0, 1'b0, 1'b1);
    end

    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      applyStimulus(r == 0, r > 25, SIZE'($urandom), $urandom_range(0, 49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
